mat_skew_feeder: RTL and testbench

Transmit-side companion to the systolic matrix-multiply array. Accepts two MxM 8-bit operand matrices (A row-wise, B row-wise) over a load handshake and buffers them. Emits the diagonally skewed per-row A stream and per-column B stream the array consumes, one wavefront per accepted beat. Ends with M-1 zero flush beats so the last processing element finishes accumulating.

---
 rtl/mat_pkg.sv | 16 +
 rtl/mat_buf.sv | 60 ++++++
 rtl/mat_skew_feeder.sv | 90 +++++++++
 tb/tb_mat_skew_feeder.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mat_pkg.sv
// Shared widths, state type and stream-length helper for the matrix skew feeder.
package mat_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;

  typedef enum logic {
    LOAD   = 1'b0,
    STREAM = 1'b1
  } feed_state_t;

  function automatic int stream_len(input int m);
    return 3 * m - 2;
  endfunction

endpackage

// File: rtl/mat_buf.sv
// MxM operand store: one row-write port, diagonal (skewed) read port indexed by beat.
module mat_buf
  import mat_pkg::*;
#(
  parameter int M  = 3,
  parameter int RW = 2,
  parameter int TW = 3
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [RW-1:0]     wr_row,
  input  logic [DATA_W-1:0] wr_a [0:M-1],
  input  logic [DATA_W-1:0] wr_b [0:M-1],
  input  logic              rd_en,
  input  logic [TW-1:0]     rd_t,
  output logic [DATA_W-1:0] a_out [0:M-1],
  output logic [DATA_W-1:0] b_out [0:M-1]
);

  logic [DATA_W-1:0] a_mem [0:M-1][0:M-1];
  logic [DATA_W-1:0] b_mem [0:M-1][0:M-1];

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < M; r++) begin
        for (int k = 0; k < M; k++) begin
          a_mem[r][k] <= '0;
          b_mem[r][k] <= '0;
        end
      end
    end else if (wr_en) begin
      for (int r = 0; r < M; r++) begin
        if (wr_row == RW'(r)) begin
          for (int k = 0; k < M; k++) begin
            a_mem[r][k] <= wr_a[k];
            b_mem[r][k] <= wr_b[k];
          end
        end
      end
    end
  end

  // Array row i sees A[i][t-i]; array column j sees B[t-j][j]; anything off-matrix is zero.
  always_comb begin
    for (int i = 0; i < M; i++) begin
      a_out[i] = '0;
      b_out[i] = '0;
    end
    for (int i = 0; i < M; i++) begin
      for (int k = 0; k < M; k++) begin
        if (rd_en && rd_t == TW'(i + k)) begin
          a_out[i] = a_mem[i][k];
          b_out[i] = b_mem[k][i];
        end
      end
    end
  end

endmodule

// File: rtl/mat_skew_feeder.sv
// Loads two MxM operands row by row, then streams the skewed wavefronts plus flush beats.
//   state  | meaning
//   LOAD   | accepting operand rows, stream idle
//   STREAM | emitting 3M-2 skewed beats to the array
module mat_skew_feeder
  import mat_pkg::*;
#(
  parameter int M = 3
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              ld_vld,
  output logic              ld_rdy,
  input  logic [DATA_W-1:0] ld_a [0:M-1],
  input  logic [DATA_W-1:0] ld_b [0:M-1],
  output logic              st_vld,
  input  logic              st_rdy,
  output logic [DATA_W-1:0] a_out [0:M-1],
  output logic [DATA_W-1:0] b_out [0:M-1],
  output logic              busy,
  output logic              done
);

  localparam int LEN = stream_len(M);
  localparam int RW  = (M > 1) ? $clog2(M) : 1;
  localparam int TW  = $clog2(LEN);

  feed_state_t   state, state_nxt;
  logic [RW-1:0] row_cnt;
  logic [TW-1:0] beat_cnt;
  logic          done_q;
  logic          ld_acc, st_acc, last_row, last_beat;

  assign ld_acc    = ld_vld && (state == LOAD);
  assign st_acc    = st_rdy && (state == STREAM);
  assign last_row  = (row_cnt == RW'(M - 1));
  assign last_beat = (beat_cnt == TW'(LEN - 1));

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == LOAD) begin
      if (ld_acc && last_row) state_nxt = STREAM;
    end else begin
      if (st_acc && last_beat) state_nxt = LOAD;
    end
  end

  always_comb begin
    ld_rdy = (state == LOAD);
    st_vld = (state == STREAM);
    busy   = (state == STREAM);
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt  <= '0;
      beat_cnt <= '0;
      done_q   <= 1'b0;
    end else begin
      if (ld_acc) row_cnt <= last_row ? '0 : row_cnt + RW'(1);
      if (st_acc) beat_cnt <= last_beat ? '0 : beat_cnt + TW'(1);
      done_q <= st_acc && last_beat;
    end
  end

  assign done = done_q;

  mat_buf #(
    .M  (M),
    .RW (RW),
    .TW (TW)
  ) u_buf (
    .CLK    (CLK),
    .rst_n  (rst_n),
    .wr_en  (ld_acc),
    .wr_row (row_cnt),
    .wr_a   (ld_a),
    .wr_b   (ld_b),
    .rd_en  (st_vld),
    .rd_t   (beat_cnt),
    .a_out  (a_out),
    .b_out  (b_out)
  );

endmodule

// File: tb/tb_mat_skew_feeder.sv
// Self-checking bench: table vectors, stall/gap/reset sequences, random operands with a systolic product model.
module tb_mat_skew_feeder;

  localparam int M   = 3;
  localparam int DW  = 8;
  localparam int LEN = 3 * M - 2;
  localparam int PW  = DW * M;

  typedef logic [DW-1:0] row_t [0:M-1];
  typedef struct {
    int          t;
    logic [PW-1:0] a;
    logic [PW-1:0] b;
  } vec_t;

  logic CLK = 1'b0;
  logic rst_n = 1'b0;
  logic ld_vld = 1'b0;
  logic st_rdy = 1'b0;
  logic ld_rdy, st_vld, busy, done;
  row_t ld_a, ld_b, a_out, b_out;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] ma [0:M-1][0:M-1];
  logic [DW-1:0] mb [0:M-1][0:M-1];
  logic [PW-1:0] cap_a [0:LEN-1];
  logic [PW-1:0] cap_b [0:LEN-1];
  vec_t vecs [0:LEN-1];

  always #5 CLK = ~CLK;

  mat_skew_feeder #(.M(M)) dut (
    .CLK    (CLK),
    .rst_n  (rst_n),
    .ld_vld (ld_vld),
    .ld_rdy (ld_rdy),
    .ld_a   (ld_a),
    .ld_b   (ld_b),
    .st_vld (st_vld),
    .st_rdy (st_rdy),
    .a_out  (a_out),
    .b_out  (b_out),
    .busy   (busy),
    .done   (done)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] pk(input row_t v);
    logic [PW-1:0] r;
    for (int i = 0; i < M; i++) r[(M-1-i)*DW +: DW] = v[i];
    return r;
  endfunction

  // Reference: beat t carries A[i][t-i] on row i and B[t-j][j] on column j.
  function automatic logic [PW-1:0] model_a(input int t);
    logic [PW-1:0] r = '0;
    for (int i = 0; i < M; i++)
      if (t - i >= 0 && t - i < M) r[(M-1-i)*DW +: DW] = ma[i][t-i];
    return r;
  endfunction

  function automatic logic [PW-1:0] model_b(input int t);
    logic [PW-1:0] r = '0;
    for (int j = 0; j < M; j++)
      if (t - j >= 0 && t - j < M) r[(M-1-j)*DW +: DW] = mb[t-j][j];
    return r;
  endfunction

  task automatic rand_mats();
    for (int i = 0; i < M; i++)
      for (int k = 0; k < M; k++) begin
        ma[i][k] = 8'($urandom_range(255));
        mb[i][k] = 8'($urandom_range(255));
      end
  endtask

  task automatic load(input bit gaps);
    int r = 0;
    int c = 0;
    while (r < M) begin
      if (gaps && (c % 2 == 1)) begin
        ld_vld = 1'b0;
        for (int k = 0; k < M; k++) begin
          ld_a[k] = 8'($urandom_range(255));
          ld_b[k] = 8'($urandom_range(255));
        end
      end else begin
        chk("load_ld_rdy", 32'(ld_rdy), 32'd1);
        chk("load_st_vld", 32'(st_vld), 32'd0);
        ld_vld = 1'b1;
        for (int k = 0; k < M; k++) begin
          ld_a[k] = ma[r][k];
          ld_b[k] = mb[r][k];
        end
        r++;
      end
      c++;
      @(negedge CLK);
    end
    ld_vld = 1'b0;
    chk("stream_start", 32'({st_vld, busy, ld_rdy}), 32'b110);
  endtask

  // mode 0: st_rdy high, 1: stall beats 1 and 4 for 3 cycles, 2: random stalls.
  task automatic stream(input int mode, input int abort_at, input bit junk);
    int t = 0;
    int cyc = 0;
    int hold = 0;
    bit stall;
    bit prev_stall = 1'b0;
    logic [PW-1:0] pa, pb;
    while (t < LEN && cyc < 100) begin
      chk("stream_flags", 32'({st_vld, busy, ld_rdy, done}), 32'b1100);
      if (prev_stall) begin
        chk("hold_a", 32'(pk(a_out)), 32'(pa));
        chk("hold_b", 32'(pk(b_out)), 32'(pb));
      end
      pa = pk(a_out);
      pb = pk(b_out);
      if (t == abort_at) begin
        rst_n = 1'b0;
        return;
      end
      case (mode)
        1:       stall = (t == 1 || t == 4) && hold < 3;
        2:       stall = ($urandom_range(3) == 0) && hold < 4;
        default: stall = 1'b0;
      endcase
      if (junk) begin
        ld_vld = 1'b1;
        for (int k = 0; k < M; k++) begin
          ld_a[k] = 8'($urandom_range(255));
          ld_b[k] = 8'($urandom_range(255));
        end
      end
      st_rdy = !stall;
      if (stall) hold++;
      else begin
        cap_a[t] = pa;
        cap_b[t] = pb;
        t++;
        hold = 0;
      end
      prev_stall = stall;
      cyc++;
      @(negedge CLK);
    end
    st_rdy = 1'b0;
    ld_vld = 1'b0;
    chk("stream_beats", 32'(t), 32'(LEN));
    chk("done_pulse", 32'({done, ld_rdy, st_vld}), 32'b110);
  endtask

  task automatic done_low();
    @(negedge CLK);
    chk("done_once", 32'(done), 32'd0);
  endtask

  task automatic check_beats();
    for (int t = 0; t < LEN; t++) begin
      chk($sformatf("beat%0d_a", t), 32'(cap_a[t]), 32'(model_a(t)));
      chk($sformatf("beat%0d_b", t), 32'(cap_b[t]), 32'(model_b(t)));
    end
  endtask

  task automatic check_table();
    for (int v = 0; v < LEN; v++) begin
      chk($sformatf("tbl%0d_a", vecs[v].t), 32'(cap_a[vecs[v].t]), 32'(vecs[v].a));
      chk($sformatf("tbl%0d_b", vecs[v].t), 32'(cap_b[vecs[v].t]), 32'(vecs[v].b));
    end
  endtask

  // PE(i,j) sees A beat tau-j and B beat tau-i; its accumulated sum must equal (A x B)[i][j].
  task automatic check_product();
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++) begin
        int gold = 0;
        int acc = 0;
        for (int k = 0; k < M; k++) gold += int'(ma[i][k]) * int'(mb[k][j]);
        for (int tau = 0; tau < LEN + 2 * (M - 1); tau++) begin
          int s = tau - j;
          int u = tau - i;
          if (s >= 0 && s < LEN && u >= 0 && u < LEN)
            acc += int'(cap_a[s][(M-1-i)*DW +: DW]) * int'(cap_b[u][(M-1-j)*DW +: DW]);
        end
        chk($sformatf("c%0d%0d", i, j), 32'(acc), 32'(gold));
      end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < M; k++) begin
      ld_a[k] = '0;
      ld_b[k] = '0;
    end
    vecs[0] = '{0, 24'h010000, 24'h010000};
    vecs[1] = '{1, 24'h020400, 24'h000000};
    vecs[2] = '{2, 24'h030507, 24'h000100};
    vecs[3] = '{3, 24'h000608, 24'h000000};
    vecs[4] = '{4, 24'h000009, 24'h000001};
    vecs[5] = '{5, 24'h000000, 24'h000000};
    vecs[6] = '{6, 24'h000000, 24'h000000};

    repeat (3) @(negedge CLK);
    chk("rst_flags", 32'({ld_rdy, st_vld, busy, done}), 32'b1000);
    chk("rst_a", 32'(pk(a_out)), 32'd0);
    chk("rst_b", 32'(pk(b_out)), 32'd0);
    rst_n = 1'b1;
    @(negedge CLK);

    // Basic skew with identity B
    for (int i = 0; i < M; i++)
      for (int k = 0; k < M; k++) begin
        ma[i][k] = 8'(i * M + k + 1);
        mb[i][k] = (i == k) ? 8'd1 : 8'd0;
      end
    load(1'b0);
    stream(0, -1, 1'b0);
    check_table();
    done_low();

    // Backpressure gives identical contents
    load(1'b0);
    stream(1, -1, 1'b0);
    check_table();
    done_low();

    // Load gaps, junk ld_vld during stream
    rand_mats();
    load(1'b1);
    stream(0, -1, 1'b1);
    check_beats();
    check_product();
    done_low();

    // Back-to-back: second load starts in the done cycle
    rand_mats();
    load(1'b0);
    stream(0, -1, 1'b0);
    for (int i = 0; i < M; i++)
      for (int k = 0; k < M; k++) begin
        ma[i][k] = 8'd2;
        mb[i][k] = 8'd2;
      end
    load(1'b0);
    stream(0, -1, 1'b0);
    chk("b2b_beat2_a", 32'(cap_a[2]), 32'h020202);
    chk("b2b_beat2_b", 32'(cap_b[2]), 32'h020202);
    check_beats();
    done_low();

    // Reset mid-stream
    rand_mats();
    load(1'b0);
    stream(0, 3, 1'b0);
    #1;
    chk("midrst_flags", 32'({ld_rdy, st_vld, busy, done}), 32'b1000);
    chk("midrst_a", 32'(pk(a_out)), 32'd0);
    chk("midrst_b", 32'(pk(b_out)), 32'd0);
    st_rdy = 1'b0;
    @(negedge CLK);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk("midrst_no_done", 32'({done, st_vld}), 32'd0);
      @(negedge CLK);
    end
    rand_mats();
    load(1'b0);
    stream(2, -1, 1'b0);
    check_beats();
    check_product();
    done_low();

    // Random operands with random stalls
    for (int n = 0; n < 4; n++) begin
      rand_mats();
      load(n[0]);
      stream(2, -1, n[1]);
      check_beats();
      check_product();
      done_low();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
